// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JALR = 2'b10,
        PCSRC_RSV  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fb_entry_t;

    // jalr clears bit0 only; bit1 is passed through unchanged
    function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] alu_result);
        return {alu_result[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO with synchronous clear (clear beats push) and a
// combinational head read; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = !clr && pop && !empty;
        // a pop in the same cycle frees the slot, so push-on-full is legal then
        do_push  = !clr && push && (!full || do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (n_rst && !clr)
            assert (!(push && full && !pop)) else $error("fetch_fifo: push into full FIFO");
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues variable-latency imem requests, buffers
// responses and drops wrong-path ones via an epoch tag. Define FETCH_PERF_CNT_EN
// to add the redirect_cnt / bubble_cnt performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              FB_DEPTH = 2
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            StallF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            validF,
    output logic [ILEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PC_plus4F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int            CW      = $clog2(FB_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);
    localparam int            EW      = ILEN + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            epoch_q, epoch_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;

    pcsrc_e          pcsrc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            issue;
    logic            accept;
    logic [CW-1:0]   in_use;

    logic [EW-1:0]   fb_rdata;
    logic            fb_empty, fb_full, fb_pop;
    logic [CW-1:0]   fb_count;
    fb_entry_t       fb_head;

    logic            tag_rdata, tag_empty, tag_full;
    logic [CW-1:0]   tag_count;

    assign pcsrc       = pcsrc_e'(PCSrcE);
    assign redirect    = (pcsrc == PCSRC_BR) || (pcsrc == PCSRC_JALR);
    assign redirect_pc = (pcsrc == PCSRC_JALR) ? jalr_target(ALUResultE) : PCTargetE;

    // outstanding + occupancy never exceeds FB_DEPTH, so the buffer cannot overflow
    assign in_use    = outstanding_q + fb_count;
    assign imem_req  = (state_q != BOOT) && (in_use < DEPTH_C);
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;

    // stale_q counts responses still owed to a previous path; with a 1-bit
    // epoch this guards against back-to-back redirects aliasing the tag
    assign accept = imem_rvalid && !redirect && (tag_rdata == epoch_q) && (stale_q == '0);

    assign fb_pop  = validF && !StallF;
    assign fb_head = fb_entry_t'(fb_rdata);

    assign validF    = !fb_empty;
    assign InstrF    = validF ? fb_head.instr         : '0;
    assign PCF       = validF ? fb_head.pc            : '0;
    assign PC_plus4F = validF ? fb_head.pc + 32'd4    : '0;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FB_DEPTH)
    ) u_fetch_buf (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (redirect),
        .push  (accept),
        .wdata ({imem_rdata, resp_pc_q}),
        .pop   (fb_pop),
        .rdata (fb_rdata),
        .empty (fb_empty),
        .full  (fb_full),
        .count (fb_count)
    );

    fetch_fifo #(
        .WIDTH (1),
        .DEPTH (FB_DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (1'b0),
        .push  (issue),
        .wdata (epoch_q),
        .pop   (imem_rvalid),
        .rdata (tag_rdata),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        epoch_d       = epoch_q;
        stale_d       = stale_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);

        if (imem_rvalid && (stale_q != '0)) stale_d = stale_q - CW'(1);
        if (accept) resp_pc_d = resp_pc_q + 32'd4;
        if (issue)  pc_d      = pc_q + 32'd4;

        // a grant in this cycle carries the old epoch and is counted as stale
        if (redirect) begin
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            epoch_d   = ~epoch_q;
            stale_d   = outstanding_d;
        end

        case (state_q)
            BOOT:      state_d = RUN;
            RUN,
            DRAIN:     state_d = (stale_d != '0) ? DRAIN : RUN;
            default:   state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            epoch_q       <= 1'b0;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            epoch_q       <= epoch_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        if ((PCSrcE != 2'b00) && (redirect_cnt_q != 32'hFFFF_FFFF))
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        if ((state_q != BOOT) && !validF && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            redirect_cnt_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (PCSrcE != 2'b11)
                else $error("fetch_unit: reserved PCSrcE=11 treated as sequential");
            assert (!(imem_req && (imem_addr[1:0] != 2'b00)))
                else $warning("fetch_unit: misaligned fetch address %h", imem_addr);
            assert (!(imem_rvalid && tag_empty))
                else $error("fetch_unit: response with no request outstanding");
            assert (!(issue && tag_full))
                else $error("fetch_unit: tag queue overflow");
            assert (tag_count == outstanding_q)
                else $error("fetch_unit: tag queue out of step with outstanding count");
            assert (!(fb_full && (outstanding_q != '0)))
                else $error("fetch_unit: fetch buffer over-committed");
        end
    end

endmodule
